// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The FSM encoding and grant-owner values are common to the top level and the round-robin grant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last wins. last_q advances only when update is high.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic gnt_valid,
    output logic gnt_owner,
    output logic last_owner
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_owner = OWN_I;
        if (req_i && req_d) begin
            gnt_owner = ~last_q;
        end else if (req_d) begin
            gnt_owner = OWN_D;
        end

        last_d = last_q;
        if (update && gnt_valid) begin
            last_d = gnt_owner;
        end
    end

    // Reset value D makes the first tie go to the fetch unit.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_q <= OWN_D;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_owner = last_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Each access is IDLE (grant) -> ACCESS (memory cycle) -> RESP (done pulse).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_q,
    output logic          busy
);

    // One extra bit lets DEPTH equal 2**AW without overflowing the bound.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic          store_q, store_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          gnt_valid;
    logic          gnt_owner;
    logic          last_owner;
    logic          arb_update;
    logic [AW-1:0] sel_addr;
    logic          sel_oor;
    logic          sel_store;
    logic [31:0]   capture;

    rr_arb2 u_rr_arb2 (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_i      (i_req),
        .req_d      (d_req),
        .update     (arb_update),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner),
        .last_owner (last_owner)
    );

    always_comb begin
        sel_addr  = (gnt_owner == OWN_D) ? d_addr : i_addr;
        sel_oor   = ({1'b0, sel_addr} >= DEPTH_EXT);
        sel_store = (gnt_owner == OWN_D) && d_we;
        capture   = err_q ? 32'd0 : mem_q;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        store_d     = store_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        arb_update  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    arb_update  = 1'b1;
                    owner_d     = gnt_owner;
                    err_d       = sel_oor;
                    store_d     = sel_store;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = (gnt_owner == OWN_D) ? d_wdata : 32'd0;
                    mem_we_d    = sel_store && !sel_oor;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Stores return nothing, so neither rdata register moves.
                if (!store_q) begin
                    if (owner_q == OWN_I) begin
                        i_rdata_d = capture;
                    end else begin
                        d_rdata_d = capture;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            err_q       <= 1'b0;
            store_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            store_q     <= store_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // A reset arriving during ACCESS must stop the store before the memory's falling-edge write.
    assign mem_we    = mem_we_q & ~Reset;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = (state_q == RESP) && (owner_q == OWN_I);
    assign d_done    = (state_q == RESP) && (owner_q == OWN_D);
    assign i_err     = i_done & err_q;
    assign d_err     = d_done & err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a falling-edge memory, a transaction-level model
// (grant order, memory contents, returned words) and per-scenario test tasks.
module tb_mem_port_arbiter;

    localparam int EW = 42;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q = 32'd0;
    logic        busy;

    logic [31:0] mem_arr [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    bit          model_last_d;
    logic [EW-1:0] exp_q[$];
    int          we_exp;
    int          we_seen;
    int          n_vec = 0;
    int          n_err = 0;

    mem_port_arbiter #(.DEPTH(1024), .AW(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    // Clock and memory: read data and writes take effect on the falling edge.
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem_addr < 32'd1024) mem_q <= mem_arr[mem_addr[9:0]];
        else                     mem_q <= 32'hBAD0BAD0;
        if (mem_we && mem_addr < 32'd1024) mem_arr[mem_addr[9:0]] <= mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        mem_arr[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic model_reset();
        exp_i_rdata  = 32'd0;
        exp_d_rdata  = 32'd0;
        model_last_d = 1'b1;
    endtask

    // Model of one served request, in grant order; queues the expected response.
    task automatic model_serve(input bit own_d, input logic [31:0] ia, input bit dwe,
                               input logic [31:0] da, input logic [31:0] dwd, input int cyc);
        bit err;
        logic [31:0] r;
        if (!own_d) begin
            err = (ia >= 32'd1024);
            exp_i_rdata = err ? 32'd0 : ref_mem[ia[9:0]];
            r = exp_i_rdata;
        end else begin
            err = (da >= 32'd1024);
            if (dwe) begin
                if (!err) begin
                    ref_mem[da[9:0]] = dwd;
                    we_exp++;
                end
            end else begin
                exp_d_rdata = err ? 32'd0 : ref_mem[da[9:0]];
            end
            r = exp_d_rdata;
        end
        exp_q.push_back({8'(cyc), own_d, err, r});
        model_last_d = own_d;
    endtask

    // Runs the clock until every queued response has been seen, checking each one.
    task automatic drain(input bit hold);
        int cyc;
        logic [EW-1:0] e;
        logic [31:0] got;
        logic gerr;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 24) begin
            step();
            cyc++;
            if (mem_we === 1'b1) we_seen++;
            if (cyc == 1) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_after_grant: got %b expected 1", busy);
                end
            end
            if (i_done === 1'b1 || d_done === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({i_done, d_done} !== (e[33] ? 2'b01 : 2'b10)) begin
                    n_err++;
                    $display("FAIL done_owner: got i_done=%b d_done=%b expected owner_d=%b",
                             i_done, d_done, e[33]);
                end
                n_vec++;
                if (cyc !== int'(e[41:34])) begin
                    n_err++;
                    $display("FAIL done_cycle: got %0d expected %0d", cyc, e[41:34]);
                end
                got  = e[33] ? d_rdata : i_rdata;
                gerr = e[33] ? d_err : i_err;
                n_vec++;
                if (got !== e[31:0]) begin
                    n_err++;
                    $display("FAIL rdata(owner_d=%b): got %h expected %h", e[33], got, e[31:0]);
                end
                n_vec++;
                if (gerr !== e[32]) begin
                    n_err++;
                    $display("FAIL err(owner_d=%b): got %b expected %b", e[33], gerr, e[32]);
                end
                if (!hold) begin
                    if (e[33]) d_req = 1'b0;
                    else       i_req = 1'b0;
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        exp_q.delete();
        i_req = 1'b0;
        d_req = 1'b0;
        n_vec++;
        if (we_seen !== we_exp) begin
            n_err++;
            $display("FAIL mem_we_cycles: got %0d expected %0d", we_seen, we_exp);
        end
        step();
        n_vec++;
        if ({i_done, d_done, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after: got i_done=%b d_done=%b busy=%b expected 000",
                     i_done, d_done, busy);
        end
    endtask

    // One round: the requesters raised together, each dropping its request at its done.
    task automatic run_txn(input bit ri, input bit rd, input logic [31:0] ia, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd);
        bit first_d;
        we_exp  = 0;
        we_seen = 0;
        first_d = (ri && rd) ? !model_last_d : rd;
        if (ri || rd) model_serve(first_d, ia, dwe, da, dwd, 2);
        if (ri && rd) model_serve(!first_d, ia, dwe, da, dwd, 5);
        i_req   = ri;
        i_addr  = ia;
        d_req   = rd;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        drain(1'b0);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        model_reset();
        n_vec++;
        if ({mem_we, i_done, d_done, i_err, d_err, busy} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_we, i_done, d_done, i_err, d_err, busy});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h i_rdata=%h d_rdata=%h expected 0",
                     mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        Reset = 1'b0;
    endtask

    task automatic test_fetch();
        preload(5, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 32'd5, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_store_load();
        run_txn(1'b0, 1'b1, 32'd0, 1'b1, 32'd10, 32'h12345678);
        run_txn(1'b0, 1'b1, 32'd0, 1'b0, 32'd10, 32'd0);
        n_vec++;
        if (mem_arr[10] !== 32'h12345678) begin
            n_err++;
            $display("FAIL store_word10: got %h expected 12345678", mem_arr[10]);
        end
    endtask

    // Both requesters held throughout: grants alternate every three cycles.
    task automatic test_back_to_back();
        Reset = 1'b1;
        step();
        model_reset();
        Reset = 1'b0;
        preload(20, 32'h20202020);
        preload(21, 32'h21212121);
        we_exp  = 0;
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            model_serve(!model_last_d, 32'd20, 1'b0, 32'd21, 32'd0, 2 + 3 * k);
        end
        i_req  = 1'b1;
        i_addr = 32'd20;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'd21;
        drain(1'b1);
    endtask

    task automatic test_out_of_range();
        run_txn(1'b0, 1'b1, 32'd0, 1'b1, 32'd1024, 32'hCAFEF00D);
        run_txn(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0);
        n_vec++;
        if (mem_arr[0] !== ref_mem[0]) begin
            n_err++;
            $display("FAIL oor_store_alias: got %h expected %h", mem_arr[0], ref_mem[0]);
        end
    endtask

    task automatic test_boundary();
        preload(1023, 32'hA5A5A5A5);
        run_txn(1'b1, 1'b0, 32'd1023, 1'b0, 32'd0, 32'd0);
        run_txn(1'b0, 1'b1, 32'd0, 1'b0, 32'd1023, 32'd0);
    endtask

    task automatic test_reset_mid();
        preload(3, 32'h33333333);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd3;
        d_wdata = 32'hFFFF0000;
        step();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        Reset = 1'b1;
        step();
        n_vec++;
        if ({mem_we, i_done, d_done, i_err, d_err, busy} !== 6'd0 ||
            {mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got we=%b done=%b%b err=%b%b busy=%b addr=%h wd=%h ir=%h dr=%h expected all 0",
                     mem_we, i_done, d_done, i_err, d_err, busy, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        Reset = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        model_reset();
        step();
        n_vec++;
        if (mem_arr[3] !== 32'h33333333) begin
            n_err++;
            $display("FAIL mid_reset_word3: got %h expected 33333333", mem_arr[3]);
        end
        run_txn(1'b1, 1'b1, 32'd3, 1'b0, 32'd5, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) begin
            return ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'd1024 + $urandom_range(0, 5000);
        end
        return 32'($urandom_range(0, 63));
    endfunction

    task automatic test_random();
        int p;
        for (int n = 0; n < 40; n++) begin
            p = $urandom_range(0, 2);
            run_txn(p != 1, p != 0, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) preload(a, $urandom);
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
